// File: rtl/apb_uart_master.sv
// APB4 initiator for the UART register block: one command in, one SETUP/ACCESS transfer out,
// one response back, with a bounded wait on pready.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// SETUP  | psel high for one cycle, penable low
// ACCESS | psel and penable high, waiting on pready or the timeout limit
// RESP   | rsp_valid high, response fields held until rsp_ready
module apb_uart_master #(
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                pclk,
   input  logic                preset_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_write,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [DATA_W-1:0]   cmd_wdata,
   input  logic [DATA_W/8-1:0] cmd_strb,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic                rsp_timeout,
   output logic                psel,
   output logic                penable,
   output logic                pwrite,
   output logic [DATA_W/8-1:0] pstrb,
   output logic [ADDR_W-1:0]   paddr,
   output logic [DATA_W-1:0]   pwdata,
   input  logic                pready,
   input  logic                pslverr,
   input  logic [DATA_W-1:0]   prdata
);

   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             timeout_hit;

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) state <= IDLE;
      else           state <= state_nxt;
   end

   // Handshake and bus-phase outputs depend on the registered state only.
   always_comb begin
      state_nxt   = state;
      cmd_ready   = 1'b0;
      psel        = 1'b0;
      penable     = 1'b0;
      rsp_valid   = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) state_nxt = SETUP;
         end
         SETUP: begin
            psel      = 1'b1;
            state_nxt = ACCESS;
         end
         ACCESS: begin
            psel    = 1'b1;
            penable = 1'b1;
            if (pready) begin
               state_nxt = RESP;
            end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
               timeout_hit = 1'b1;
               state_nxt   = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         pwrite      <= 1'b0;
         paddr       <= '0;
         pwdata      <= '0;
         pstrb       <= '0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
         cnt         <= '0;
      end else begin
         if (state == IDLE && cmd_valid) begin
            pwrite <= cmd_write;
            paddr  <= cmd_addr;
            pwdata <= cmd_wdata;
            pstrb  <= cmd_write ? cmd_strb : '0;
         end

         // Counter restarts every transfer and stops at the limit, so it never wraps.
         if (state == SETUP)
            cnt <= '0;
         else if (state == ACCESS && !pready && !timeout_hit)
            cnt <= cnt + CNT_W'(1);

         if (state == ACCESS) begin
            if (pready) begin
               rsp_rdata   <= pwrite ? '0 : prdata;
               rsp_err     <= pslverr;
               rsp_timeout <= 1'b0;
            end else if (timeout_hit) begin
               rsp_rdata   <= '0;
               rsp_err     <= 1'b1;
               rsp_timeout <= 1'b1;
            end
         end
      end
   end

endmodule
